// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_pkg
// Purpose  : Definitions shared by the FIR stimulus source and the filter
//            datapath: mode encoding, stimulus FSM state type and the
//            saturating clamp used by the stimulus patterns and the filter's
//            output stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package filter_pkg;

  // Stimulus pattern selection
  localparam logic [1:0] MODE_IMPULSE = 2'd0;
  localparam logic [1:0] MODE_STEP    = 2'd1;
  localparam logic [1:0] MODE_RAMP    = 2'd2;
  localparam logic [1:0] MODE_ALT     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } stim_state_t;

  // Clamp a wide signed value into the signed range of a 'width'-bit word.
  // The caller truncates the result to 'width' bits; valid for width <= 31.
  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] val,
    input int                 width
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end else begin
      return val;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_pattern.sv
`default_nettype none
// ============================================================================
// Module   : stim_pattern
// Purpose  : Combinational stimulus sample generator. Produces
//            pattern(mode, amp, idx), saturated to the DATA_W signed range.
// Ports    : mode   - pattern select (impulse/step/ramp/alternating)
//            amp    - signed amplitude
//            idx    - index of the pattern sample
//            sample - saturated signed output sample
// Revision : 1.0 - initial release
// ============================================================================
module stim_pattern
  import filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic        [1:0]        mode,
  input  logic signed [DATA_W-1:0] amp,
  input  logic        [LEN_W-1:0]  idx,
  output logic signed [DATA_W-1:0] sample
);

  // Raw value formed wide enough that no intermediate can wrap (covers the
  // negation of the most negative amplitude and the ramp's idx+1).
  logic signed [31:0] raw;

  always_comb begin
    raw = 32'sd0;
    case (mode)
      MODE_IMPULSE: raw = (idx == '0) ? 32'(amp) : 32'sd0;
      MODE_STEP:    raw = 32'(amp);
      MODE_RAMP:    raw = 32'(idx) + 32'sd1;
      MODE_ALT:     raw = idx[0] ? -32'(amp) : 32'(amp);
      default:      raw = 32'sd0;
    endcase
  end

  assign sample = DATA_W'(sat_signed(raw, DATA_W));

endmodule
`default_nettype wire

// File: rtl/filter_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : filter_stim_gen
// Purpose  : Finite test-sequence source for the FIR datapath. On start it
//            streams 'length' pattern samples followed by ZERO_PAD zeros over
//            a valid/ready interface, then pulses done for one cycle.
// Ports    : clk, reset            - clock, async active-high reset
//            start                 - begin a sequence (accepted in IDLE only)
//            mode, amp, length     - sequence parameters, captured on start
//            out_ready             - downstream accepts a sample
//            x_out, x_valid        - sample stream
//            sample_idx            - current pattern index (0 during flush)
//            busy, done            - activity flag, end-of-sequence pulse
// Revision : 1.0 - initial release
// ============================================================================
module filter_stim_gen
  import filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 8,
  parameter int ZERO_PAD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic        [1:0]        mode,
  input  logic signed [DATA_W-1:0] amp,
  input  logic        [LEN_W-1:0]  length,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     x_valid,
  output logic        [LEN_W-1:0]  sample_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int               PAD_W    = (ZERO_PAD > 1) ? $clog2(ZERO_PAD) : 1;
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'((ZERO_PAD > 0) ? (ZERO_PAD - 1) : 0);

  stim_state_t               state, state_next;
  logic        [1:0]         mode_q, mode_next;
  logic signed [DATA_W-1:0]  amp_q, amp_next;
  logic        [LEN_W-1:0]   len_q, len_next;
  logic        [LEN_W-1:0]   idx_q, idx_next;
  logic        [PAD_W-1:0]   pad_q, pad_next;
  logic signed [DATA_W-1:0]  pattern_next;
  logic                      xfer;

  // x_valid is registered and high exactly in RUN/FLUSH
  assign xfer = x_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    amp_next   = amp_q;
    len_next   = len_q;
    idx_next   = idx_q;
    pad_next   = pad_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          mode_next = mode;
          amp_next  = amp;
          len_next  = length;
          idx_next  = '0;
          pad_next  = '0;
          if (length != '0) begin
            state_next = ST_RUN;
          end else if (ZERO_PAD != 0) begin
            state_next = ST_FLUSH;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            pad_next = '0;
            if (ZERO_PAD != 0) begin
              state_next = ST_FLUSH;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            idx_next = idx_q + LEN_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (xfer) begin
          if (pad_q == PAD_LAST) begin
            state_next = ST_DONE;
          end else begin
            pad_next = pad_q + PAD_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pattern evaluated on the next-cycle fields so every output can be
  // registered while sample 0 still appears right after the start edge.
  stim_pattern #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_pattern (
    .mode   (mode_next),
    .amp    (amp_next),
    .idx    (idx_next),
    .sample (pattern_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_IMPULSE;
      amp_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      pad_q      <= '0;
      x_out      <= '0;
      x_valid    <= 1'b0;
      sample_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mode_q     <= mode_next;
      amp_q      <= amp_next;
      len_q      <= len_next;
      idx_q      <= idx_next;
      pad_q      <= pad_next;
      x_valid    <= (state_next == ST_RUN) || (state_next == ST_FLUSH);
      x_out      <= (state_next == ST_RUN) ? pattern_next : '0;
      sample_idx <= (state_next == ST_RUN) ? idx_next : '0;
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_stim_gen
// Purpose  : Directed self-checking bench for filter_stim_gen. A second
//            instance with ZERO_PAD=0 covers the no-flush paths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_stim_gen;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, start2;
  logic        [1:0] mode;
  logic signed [7:0] amp;
  logic        [7:0] length;
  logic              out_ready;

  logic signed [7:0] x_out, x_out2;
  logic              x_valid, x_valid2;
  logic        [7:0] sample_idx, sample_idx2;
  logic              busy, busy2, done, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_stim_gen #(.DATA_W(8), .LEN_W(8), .ZERO_PAD(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amp(amp),
    .length(length), .out_ready(out_ready), .x_out(x_out), .x_valid(x_valid),
    .sample_idx(sample_idx), .busy(busy), .done(done)
  );

  filter_stim_gen #(.DATA_W(8), .LEN_W(8), .ZERO_PAD(0)) u_dut_nopad (
    .clk(clk), .reset(reset), .start(start2), .mode(mode), .amp(amp),
    .length(length), .out_ready(out_ready), .x_out(x_out2), .x_valid(x_valid2),
    .sample_idx(sample_idx2), .busy(busy2), .done(done2)
  );

  task automatic check_eq(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sequence, then scramble the inputs to prove they were captured.
  task automatic start_seq(input logic [1:0] m, input int a, input int l);
    mode   = m;
    amp    = 8'(a);
    length = 8'(l);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mode   = ~m;
    amp    = -amp;
    length = length + 8'd7;
  endtask

  // Called in the first cycle after the start edge, out_ready high.
  task automatic expect_samples(input string tag, input int exp[$], input int len, input bit poke);
    foreach (exp[i]) begin
      check_eq({tag, "_valid"}, int'(x_valid), 1);
      check_eq({tag, "_x"}, int'(x_out), exp[i]);
      check_eq({tag, "_idx"}, int'(sample_idx), (i < len) ? i : 0);
      check_eq({tag, "_busy"}, int'(busy), 1);
      if (poke && i == 1) begin
        start  = 1'b1;
        mode   = 2'd2;
        length = 8'd9;
      end
      tick();
      start = 1'b0;
    end
    check_eq({tag, "_done"}, int'(done), 1);
    check_eq({tag, "_done_valid"}, int'(x_valid), 0);
    check_eq({tag, "_done_busy"}, int'(busy), 1);
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_after_done"}, int'(done), 0);
    check_eq({tag, "_after_busy"}, int'(busy), 0);
    check_eq({tag, "_after_valid"}, int'(x_valid), 0);
  endtask

  initial begin
    int q[$];
    int got[$];
    int bp_exp[$];
    bit seen_done;

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    mode = 2'd0; amp = 8'sd0; length = 8'd0; out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_x", int'(x_out), 0);
    check_eq("rst_valid", int'(x_valid), 0);
    check_eq("rst_idx", int'(sample_idx), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_valid2", int'(x_valid2), 0);
    check_eq("rst_done2", int'(done2), 0);
    reset = 1'b0;
    tick();

    // Impulse: 5,0,0 then four zeros, done in cycle 8
    start_seq(2'd0, 5, 3);
    q = '{5, 0, 0, 0, 0, 0, 0};
    expect_samples("impulse", q, 3, 1'b0);

    // Ramp length 4 (started back-to-back in the cycle after done)
    start_seq(2'd2, 99, 4);
    q = '{1, 2, 3, 4, 0, 0, 0, 0};
    expect_samples("ramp4", q, 4, 1'b0);

    // Ramp length 200: saturates at 127 from idx 126
    q.delete();
    for (int i = 0; i < 204; i++) begin
      if (i >= 200)      q.push_back(0);
      else if (i >= 126) q.push_back(127);
      else               q.push_back(i + 1);
    end
    start_seq(2'd2, 0, 200);
    expect_samples("ramp200", q, 200, 1'b0);

    // Alternating with most negative amplitude
    start_seq(2'd3, -128, 2);
    q = '{-128, 127, 0, 0, 0, 0};
    expect_samples("alt_sat", q, 2, 1'b0);

    // Alternating, ordinary amplitude
    start_seq(2'd3, -7, 3);
    q = '{-7, 7, -7, 0, 0, 0, 0};
    expect_samples("alt", q, 3, 1'b0);

    // Length 0: only the zero pad
    start_seq(2'd1, 9, 0);
    q = '{0, 0, 0, 0};
    expect_samples("len0", q, 0, 1'b0);

    // Start pulsed in RUN and in the DONE cycle: both ignored
    start_seq(2'd1, 2, 2);
    q = '{2, 2, 0, 0, 0, 0};
    expect_samples("start_busy", q, 2, 1'b1);
    tick();
    check_eq("start_busy_idle_valid", int'(x_valid), 0);
    check_eq("start_busy_idle_busy", int'(busy), 0);

    // Backpressure: stall three cycles while idx=1
    bp_exp = '{3, 3, 3, 0, 0, 0, 0};
    got.delete();
    seen_done = 1'b0;
    start_seq(2'd1, 3, 3);
    for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (cyc >= 3 && cyc <= 5) begin
          check_eq("bp_hold_valid", int'(x_valid), 1);
          check_eq("bp_hold_x", int'(x_out), 3);
          check_eq("bp_hold_idx", int'(sample_idx), 1);
        end
        if (x_valid && out_ready) got.push_back(int'(x_out));
        tick();
      end
    end
    out_ready = 1'b1;
    check_eq("bp_done_seen", int'(seen_done), 1);
    check_eq("bp_transfers", got.size(), 7);
    foreach (bp_exp[i]) begin
      check_eq("bp_sample", (i < got.size()) ? got[i] : -999, bp_exp[i]);
    end
    tick();

    // ZERO_PAD=0, length 0: done one cycle after start, never valid
    mode = 2'd1; amp = 8'sd4; length = 8'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("nopad0_done", int'(done2), 1);
    check_eq("nopad0_valid", int'(x_valid2), 0);
    check_eq("nopad0_busy", int'(busy2), 1);
    tick();
    check_eq("nopad0_after_done", int'(done2), 0);
    check_eq("nopad0_after_valid", int'(x_valid2), 0);
    check_eq("nopad0_after_busy", int'(busy2), 0);

    // ZERO_PAD=0, step length 2: 4,4 then done
    length = 8'd2;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("nopad2_x0", int'(x_out2), 4);
    check_eq("nopad2_v0", int'(x_valid2), 1);
    tick();
    check_eq("nopad2_x1", int'(x_out2), 4);
    check_eq("nopad2_idx1", int'(sample_idx2), 1);
    tick();
    check_eq("nopad2_done", int'(done2), 1);
    check_eq("nopad2_done_valid", int'(x_valid2), 0);
    tick();
    check_eq("nopad2_after_done", int'(done2), 0);

    // Mid-run reset at idx=2, then a clean full sequence
    start_seq(2'd2, 0, 5);
    tick();
    tick();
    check_eq("mrst_pre_idx", int'(sample_idx), 2);
    check_eq("mrst_pre_x", int'(x_out), 3);
    #2 reset = 1'b1;
    #1;
    check_eq("mrst_x", int'(x_out), 0);
    check_eq("mrst_valid", int'(x_valid), 0);
    check_eq("mrst_idx", int'(sample_idx), 0);
    check_eq("mrst_busy", int'(busy), 0);
    check_eq("mrst_done", int'(done), 0);
    tick();
    tick();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || x_valid) seen_done = 1'b1;
      tick();
    end
    check_eq("mrst_no_done", int'(seen_done), 0);
    start_seq(2'd2, 0, 5);
    q = '{1, 2, 3, 4, 5, 0, 0, 0, 0};
    expect_samples("mrst_rerun", q, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
